// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper move controller.
// The phase table walks the 8-entry half-step sequence; full steps skip every other entry.
package stepper_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int PH_W = 3;

  // Coil pattern {A,B,C,D} per phase index.
  // Even entries drive one coil; odd entries drive two.
  localparam logic [3:0] PHASE_TBL [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

endpackage

// File: rtl/step_timer.sv
// Step-rate divider: emits a one-cycle tick every i_period enabled clocks.
// The count is held at zero while cleared, so the first tick follows a clear by exactly i_period cycles.
module step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_term;

  // i_period is never zero here; the caller clamps it to at least 1.
  assign w_term = (r_cnt == i_period - DIV_W'(1));
  assign o_tick = i_en & w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= w_term ? '0 : r_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/stepper_ctrl.sv
// Stepper move controller: accepts a move on a start edge and steps the coils at a programmed rate.
// The rotor phase index survives between moves so consecutive moves stay mechanically continuous.
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic             i_half,
  input  logic [CNT_W-1:0] i_steps,
  input  logic [DIV_W-1:0] i_period,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_aborted,
  output logic [CNT_W-1:0] o_remaining,
  output logic [3:0]       o_coil
);

  state_t            r_state;
  logic              r_start_d;
  logic              r_dir;
  logic              r_half;
  logic [DIV_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_rem;
  logic [PH_W-1:0]   r_idx;
  logic [3:0]        r_coil;
  logic              r_ready;
  logic              r_done;
  logic              r_aborted;

  logic              w_accept;
  logic              w_tick;
  logic [PH_W-1:0]   w_delta;
  logic [PH_W-1:0]   w_idx_nxt;

  assign w_accept  = i_start & ~r_start_d & r_ready;
  assign w_delta   = r_half ? PH_W'(1) : PH_W'(2);
  assign w_idx_nxt = r_dir ? r_idx + w_delta : r_idx - w_delta;

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (r_state != S_RUN),
    .i_en     (r_state == S_RUN),
    .i_period (r_period),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_start_d <= 1'b1;
      r_dir     <= 1'b0;
      r_half    <= 1'b0;
      r_period  <= DIV_W'(1);
      r_rem     <= '0;
      r_idx     <= '0;
      r_coil    <= PHASE_TBL[0];
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_start_d <= i_start;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir     <= i_dir;
            r_half    <= i_half;
            r_period  <= (i_period == '0) ? DIV_W'(1) : i_period;
            r_rem     <= i_steps;
            r_aborted <= 1'b0;
            r_ready   <= 1'b0;
            if (i_steps == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Abort beats a coincident tick: no step is issued and remaining stays put.
          if (i_abort) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end else if (w_tick) begin
            r_idx  <= w_idx_nxt;
            r_coil <= PHASE_TBL[w_idx_nxt];
            r_rem  <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_done      = r_done;
  assign o_aborted   = r_aborted;
  assign o_remaining = r_rem;
  assign o_coil      = r_coil;

endmodule

// File: tb/tb_stepper_ctrl.sv
// Bench for stepper_ctrl: a move table drives commands, a phase model predicts every coil
// change and done pulse (with its cycle), and a monitor pops and compares them as they occur.
module tb_stepper_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b1;
  logic        i_dir = 1'b0;
  logic        i_half = 1'b0;
  logic [15:0] i_steps = '0;
  logic [15:0] i_period = '0;
  logic        i_abort = 1'b0;
  logic        o_ready, o_done, o_aborted;
  logic [15:0] o_remaining;
  logic [3:0]  o_coil;

  stepper_ctrl #(.CNT_W(16), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_dir(i_dir), .i_half(i_half),
    .i_steps(i_steps), .i_period(i_period), .i_abort(i_abort),
    .o_ready(o_ready), .o_done(o_done), .o_aborted(o_aborted),
    .o_remaining(o_remaining), .o_coil(o_coil)
  );

  always #5 clk = ~clk;

  typedef struct {
    int steps;
    bit dir;
    bit half;
    int period;
    int abort_k;  // abort during the cycle of this tick number; 0 = none
    bit spur;     // extra start pulse while the move runs
  } vec_t;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [3:0]  coil;
    logic [15:0] rem;
    bit          ab;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_coil;
  logic [2:0] m_idx = 3'd0;

  function automatic logic [3:0] tb_coil(input logic [2:0] i);
    case (i)
      3'd0: return 4'b1000;
      3'd1: return 4'b1100;
      3'd2: return 4'b0100;
      3'd3: return 4'b0110;
      3'd4: return 4'b0010;
      3'd5: return 4'b0011;
      3'd6: return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void check_ev(input bit kind);
    ev_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d coil %b want none (cycle %0d)", kind, o_coil, cyc);
      return;
    end
    e = q.pop_front();
    chk("ev_kind", 32'(kind), 32'(e.is_done));
    chk("ev_cycle", cyc, e.cyc);
    chk("ev_remaining", 32'(o_remaining), 32'(e.rem));
    if (kind) chk("ev_aborted", 32'(o_aborted), 32'(e.ab));
    else      chk("ev_coil", 32'(o_coil), 32'(e.coil));
  endfunction

  // Sample just after each rising edge; sample number cyc reflects state after edge cyc.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mon_en) begin
      if (o_coil !== prev_coil) check_ev(1'b0);
      if (o_done === 1'b1)      check_ev(1'b1);
    end
    prev_coil = o_coil;
  end

  task automatic wait_until(input int tgt, input string name);
    int g = 0;
    while (cyc < tgt && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) chk({name, "_timeout"}, 32'(cyc), 32'(tgt));
  endtask

  task automatic run_move(input vec_t v);
    int t, pe, nst, dcyc, rem_end;
    bit ab;
    logic [2:0] d;
    ev_t e;
    pe = (v.period == 0) ? 1 : v.period;
    d  = v.half ? 3'd1 : 3'd2;
    i_steps = 16'(v.steps); i_dir = v.dir; i_half = v.half; i_period = 16'(v.period);
    @(negedge clk); i_start = 1'b0;
    @(negedge clk); i_start = 1'b1;
    t  = cyc + 1;
    ab = (v.abort_k > 0) && (v.steps > 0);
    nst = ab ? v.abort_k - 1 : v.steps;
    for (int j = 1; j <= nst; j++) begin
      m_idx = v.dir ? m_idx + d : m_idx - d;
      e = '{is_done: 1'b0, cyc: t + j * pe, coil: tb_coil(m_idx), rem: 16'(v.steps - j), ab: 1'b0};
      q.push_back(e);
    end
    dcyc    = ab ? t + v.abort_k * pe : t + v.steps * pe;
    rem_end = v.steps - nst;
    e = '{is_done: 1'b1, cyc: dcyc, coil: 4'b0, rem: 16'(rem_end), ab: ab};
    q.push_back(e);
    @(negedge clk); i_start = 1'b0;
    chk("ready_after_accept", 32'(o_ready), 32'd0);
    if (ab) begin
      wait_until(dcyc - 1, "abort");
      i_abort = 1'b1;
      @(negedge clk); i_abort = 1'b0;
    end
    if (v.spur) begin
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
    end
    wait_until(dcyc + 1, "move");
    chk("ready_after_done", 32'(o_ready), 32'd1);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("aborted_held", 32'(o_aborted), 32'(ab));
    chk("remaining_final", 32'(o_remaining), 32'(rem_end));
    chk("events_left", 32'(q.size()), 32'd0);
    q.delete();
    if (v.spur) begin
      repeat (3) @(negedge clk);
      chk("spur_not_replayed", 32'(o_ready), 32'd1);
    end
  endtask

  vec_t vt[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    //        steps dir half period abort spur
    vt[0] = '{4,   1, 1, 3, 0, 0};  // 1100,0100,0110,0010
    vt[1] = '{4,   0, 1, 1, 0, 0};  // back to index 0
    vt[2] = '{3,   0, 0, 1, 0, 0};  // 0001,0010,0100
    vt[3] = '{3,   0, 0, 0, 0, 0};  // period 0 behaves as 1
    vt[4] = '{10,  1, 0, 5, 3, 0};  // abort on 3rd tick
    vt[5] = '{0,   1, 1, 4, 0, 0};  // zero-step move
    vt[6] = '{5,   1, 1, 2, 0, 1};  // start pulse during run
    vt[7] = '{2,   1, 0, 1, 1, 0};  // abort on first tick
    vt[8] = '{6,   0, 1, 2, 0, 0};  // odd index, reverse wrap

    // Reset with start held high: no edge, so no accept.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_coil", 32'(o_coil), 32'b1000);
    chk("reset_remaining", 32'(o_remaining), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_aborted", 32'(o_aborted), 32'd0);
    prev_coil = o_coil;
    mon_en = 1'b1;

    for (int k = 0; k < 9; k++) run_move(vt[k]);

    // Abort while idle is ignored.
    @(negedge clk); i_abort = 1'b1;
    repeat (2) @(negedge clk); i_abort = 1'b0;
    chk("idle_abort_ready", 32'(o_ready), 32'd1);
    chk("idle_abort_flag", 32'(o_aborted), 32'd0);

    // Reset in the middle of a move: coil returns to phase 0, no done.
    mon_en = 1'b0;
    i_steps = 16'd8; i_dir = 1'b1; i_half = 1'b1; i_period = 16'd2;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midmove_coil", 32'(o_coil), 32'(tb_coil(m_idx + 3'd2)));
    chk("midmove_remaining", 32'(o_remaining), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("async_reset_coil", 32'(o_coil), 32'b1000);
    @(negedge clk);
    chk("midreset_ready", 32'(o_ready), 32'd1);
    chk("midreset_remaining", 32'(o_remaining), 32'd0);
    rst_n = 1'b1;
    m_idx = 3'd0;
    repeat (20) @(negedge clk);
    chk("midreset_no_done", 32'(o_done), 32'd0);
    chk("midreset_coil_kept", 32'(o_coil), 32'b1000);
    prev_coil = o_coil;
    mon_en = 1'b1;

    // Index was cleared by reset: one forward half step gives 1100.
    run_move('{1, 1, 1, 1, 0, 0});

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
